ram_bist8x64k: RTL and testbench

Built-in self-test and fill engine sitting directly upstream of `ram8x64k`. It owns the RAM's `we`/`addr`/`din` port and consumes its registered `dout`. On `start` it writes a selected data pattern over an inclusive address window, reads the window back, and compares every byte against the expected value. It reports pass/fail, an error count and the first failing location to the system controller.

---
 rtl/ram_bist8x64k.sv | 180 ++++++++++++++++++
 tb/tb_ram_bist8x64k.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist8x64k.sv
// ram_bist8x64k: fill-and-verify engine for the 64K x 8 RAM.
// Writes a pattern over an inclusive, wrapping address window, reads it back
// through a two-stage compare pipeline and reports pass/fail with first-error info.
module ram_bist8x64k #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] fill_value,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_exp_data
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] base_q, last_q, addr_q, addr_inc;
    logic [1:0]        sel_q;
    logic [DATA_W-1:0] fill_q, exp_q;
    logic              cmp_v;
    logic              launch, kill;
    logic              mismatch;
    logic [15:0]       err_count_upd;

    // Pattern generator; only the low address byte matters for every pattern.
    function automatic logic [7:0] pattern_of(input logic [1:0] sel,
                                              input logic [7:0] fill,
                                              input logic [7:0] addr_lo);
        case (sel)
            2'd0:    pattern_of = fill;
            2'd1:    pattern_of = addr_lo;
            2'd2:    pattern_of = addr_lo[0] ? 8'hAA : 8'h55;
            default: pattern_of = ~addr_lo;
        endcase
    endfunction

    assign addr_inc      = ram_addr + 1'b1;
    assign mismatch      = cmp_v && (ram_dout != exp_q);
    assign err_count_upd = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

    // State register with asynchronous return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: address equality ends each phase; abort beats start while busy.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        kill       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    kill       = 1'b1;
                    state_next = IDLE;
                end else if (ram_addr == last_q) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (abort) begin
                    kill       = 1'b1;
                    state_next = IDLE;
                end else if (ram_addr == last_q) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    kill       = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: config latch, RAM port drive, compare pipeline and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q         <= '0;
            last_q         <= '0;
            sel_q          <= '0;
            fill_q         <= '0;
            exp_q          <= '0;
            addr_q         <= '0;
            cmp_v          <= 1'b0;
            ram_we         <= 1'b0;
            ram_addr       <= '0;
            ram_din        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            first_exp_data <= '0;
        end else if (launch) begin
            base_q         <= base_addr;
            last_q         <= last_addr;
            sel_q          <= pattern_sel;
            fill_q         <= fill_value;
            cmp_v          <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            first_exp_data <= '0;
            ram_we         <= 1'b1;
            ram_addr       <= base_addr;
            ram_din        <= pattern_of(pattern_sel, fill_value, base_addr[7:0]);
        end else if (kill) begin
            ram_we <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cmp_v  <= 1'b0;
        end else begin
            if (mismatch) begin
                err_count <= err_count_upd;
                if (err_count == 16'd0) begin
                    first_err_addr <= addr_q;
                    first_err_data <= ram_dout;
                    first_exp_data <= exp_q;
                end
            end
            case (state)
                WRITE: begin
                    if (ram_addr == last_q) begin
                        ram_we   <= 1'b0;
                        ram_addr <= base_q;
                    end else begin
                        ram_addr <= addr_inc;
                        ram_din  <= pattern_of(sel_q, fill_q, addr_inc[7:0]);
                    end
                end
                READ: begin
                    exp_q  <= pattern_of(sel_q, fill_q, ram_addr[7:0]);
                    addr_q <= ram_addr;
                    cmp_v  <= 1'b1;
                    if (ram_addr != last_q) ram_addr <= addr_inc;
                end
                DRAIN: begin
                    cmp_v <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count_upd == 16'd0);
                end
                default: cmp_v <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist8x64k.sv
// tb_ram_bist8x64k: directed bench with a behavioural 64K x 8 RAM and write monitor.
module tb_ram_bist8x64k;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] base_addr;
    logic [15:0] last_addr;
    logic [1:0]  pattern_sel;
    logic [7:0]  fill_value;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] first_err_addr;
    logic [7:0]  first_err_data;
    logic [7:0]  first_exp_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem [0:65535];
    logic        fault_en   = 1'b0;
    logic [15:0] fault_addr = 16'h0000;

    logic [1:0]  m_sel;
    logic [7:0]  m_fill;
    logic [15:0] m_exp_addr;
    int          wr_cnt = 0;
    int          wr_bad = 0;

    ram_bist8x64k dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .last_addr      (last_addr),
        .pattern_sel    (pattern_sel),
        .fill_value     (fill_value),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data),
        .first_exp_data (first_exp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pattern written independently of the design's encoding.
    function automatic logic [7:0] model_pat(input logic [1:0] s, input logic [7:0] f,
                                             input logic [15:0] a);
        case (s)
            2'd0:    return f;
            2'd1:    return a[7:0];
            2'd2:    return (a[0] == 1'b1) ? 8'hAA : 8'h55;
            default: return 8'hFF - a[7:0];
        endcase
    endfunction

    // Behavioural RAM: registered read, optional forced read value at one address.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        if (fault_en && ram_addr == fault_addr) ram_dout <= 8'hFF;
        else                                    ram_dout <= mem[ram_addr];
    end

    // Write monitor: every presented write must be the next address with the model data.
    always @(negedge clk) begin
        if (rst_n && ram_we) begin
            if (ram_addr !== m_exp_addr || ram_din !== model_pat(m_sel, m_fill, m_exp_addr))
                wr_bad <= wr_bad + 1;
            wr_cnt     <= wr_cnt + 1;
            m_exp_addr <= m_exp_addr + 16'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one run and count edges after the start edge until done (or an event).
    task automatic applyStimulus(input logic [15:0] b, input logic [15:0] l,
                                 input logic [1:0] s, input logic [7:0] f,
                                 input int poke_at, input int abort_at, input int rst_at,
                                 output int cycles);
        logic [15:0] span;
        int          limit;
        span  = l - b;
        limit = 2 * (int'(span) + 1) + 40;
        @(negedge clk);
        m_sel       = s;
        m_fill      = f;
        m_exp_addr  = b;
        wr_cnt      = 0;
        wr_bad      = 0;
        base_addr   = b;
        last_addr   = l;
        pattern_sel = s;
        fill_value  = f;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start       = 1'b0;
        base_addr   = 16'h7777;
        last_addr   = 16'h1111;
        pattern_sel = ~s;
        fill_value  = ~f;
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        cycles = 0;
        while (cycles < limit) begin
            if (rst_at != 0 && cycles == rst_at) begin
                rst_n = 1'b0;
                break;
            end
            if (abort_at != 0 && cycles == abort_at) abort = 1'b1;
            if (poke_at != 0 && cycles == poke_at) start = 1'b1;
            @(posedge clk);
            cycles++;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            if (done) break;
            if (abort_at != 0 && cycles == abort_at + 1) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        base_addr   = 16'h0;
        last_addr   = 16'h0;
        pattern_sel = 2'd0;
        fill_value  = 8'h0;
        m_sel       = 2'd0;
        m_fill      = 8'h0;
        m_exp_addr  = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_busy",     {31'd0, busy},   32'd0);
        checkOutput("rst_done",     {31'd0, done},   32'd0);
        checkOutput("rst_pass",     {31'd0, pass},   32'd0);
        checkOutput("rst_we",       {31'd0, ram_we}, 32'd0);
        checkOutput("rst_addr",     {16'd0, ram_addr}, 32'd0);
        checkOutput("rst_err_cnt",  {16'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Constant fill 0..255 with a start pulse while busy
        applyStimulus(16'h0000, 16'h00FF, 2'd0, 8'h5A, 5, 0, 0, cyc);
        checkOutput("t1_cycles",  cyc, 32'd513);
        checkOutput("t1_done",    {31'd0, done}, 32'd1);
        checkOutput("t1_busy",    {31'd0, busy}, 32'd0);
        checkOutput("t1_pass",    {31'd0, pass}, 32'd1);
        checkOutput("t1_errs",    {16'd0, err_count}, 32'd0);
        checkOutput("t1_wr_cnt",  wr_cnt, 32'd256);
        checkOutput("t1_wr_bad",  wr_bad, 32'd0);
        checkOutput("t1_mem80",   {24'd0, mem[16'h0080]}, 32'h5A);

        // Abort while done has no effect
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        checkOutput("idle_abort_done", {31'd0, done}, 32'd1);

        // Wrapping window with address pattern
        applyStimulus(16'hFFFE, 16'h0001, 2'd1, 8'h00, 0, 0, 0, cyc);
        checkOutput("t2_cycles", cyc, 32'd9);
        checkOutput("t2_pass",   {31'd0, pass}, 32'd1);
        checkOutput("t2_wr_cnt", wr_cnt, 32'd4);
        checkOutput("t2_wr_bad", wr_bad, 32'd0);
        checkOutput("t2_memFFFF", {24'd0, mem[16'hFFFF]}, 32'hFF);

        // Single-address window with alternating pattern
        applyStimulus(16'h8000, 16'h8000, 2'd2, 8'h00, 0, 0, 0, cyc);
        checkOutput("t3_cycles", cyc, 32'd3);
        checkOutput("t3_pass",   {31'd0, pass}, 32'd1);
        checkOutput("t3_wr_cnt", wr_cnt, 32'd1);
        checkOutput("t3_mem8000", {24'd0, mem[16'h8000]}, 32'h55);

        // Forced read fault at 0x0010 with inverted-address pattern
        fault_addr = 16'h0010;
        fault_en   = 1'b1;
        applyStimulus(16'h0000, 16'h001F, 2'd3, 8'h00, 0, 0, 0, cyc);
        fault_en   = 1'b0;
        checkOutput("t4_cycles",   cyc, 32'd65);
        checkOutput("t4_pass",     {31'd0, pass}, 32'd0);
        checkOutput("t4_errs",     {16'd0, err_count}, 32'd1);
        checkOutput("t4_err_addr", {16'd0, first_err_addr}, 32'h0010);
        checkOutput("t4_err_data", {24'd0, first_err_data}, 32'hFF);
        checkOutput("t4_exp_data", {24'd0, first_exp_data}, 32'hEF);

        // Abort during the 5th read cycle of a 0..63 run
        applyStimulus(16'h0000, 16'h003F, 2'd1, 8'h00, 0, 68, 0, cyc);
        checkOutput("t5_cycles",   cyc, 32'd69);
        checkOutput("t5_busy",     {31'd0, busy},   32'd0);
        checkOutput("t5_done",     {31'd0, done},   32'd0);
        checkOutput("t5_we",       {31'd0, ram_we}, 32'd0);
        checkOutput("t5_err_addr", {16'd0, first_err_addr}, 32'h0000);
        applyStimulus(16'h0000, 16'h003F, 2'd1, 8'h00, 0, 0, 0, cyc);
        checkOutput("t5b_cycles", cyc, 32'd129);
        checkOutput("t5b_pass",   {31'd0, pass}, 32'd1);
        checkOutput("t5b_wr_bad", wr_bad, 32'd0);

        // Reset mid-write: outputs clear immediately, then a short run recovers
        applyStimulus(16'h0000, 16'h00FF, 2'd0, 8'h3C, 4, 0, 10, cyc);
        #1;
        checkOutput("t6_busy", {31'd0, busy},   32'd0);
        checkOutput("t6_we",   {31'd0, ram_we}, 32'd0);
        checkOutput("t6_addr", {16'd0, ram_addr}, 32'd0);
        checkOutput("t6_din",  {24'd0, ram_din},  32'd0);
        checkOutput("t6_done", {31'd0, done},   32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'h1000, 16'h1001, 2'd0, 8'hC3, 2, 0, 0, cyc);
        checkOutput("t6b_cycles", cyc, 32'd5);
        checkOutput("t6b_pass",   {31'd0, pass}, 32'd1);
        checkOutput("t6b_wr_cnt", wr_cnt, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
